id_ex_pipe_reg: RTL and testbench

//  ID->EX pipeline register with built-in load-use hazard detection and bubble insertion.

---
 rtl/id_ex_pipe_reg.sv | 79 +++++++
 tb/tb_id_ex_pipe_reg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register with load-use stall and bubble insertion.
// Define ID_EX_BUBBLE_CNT_EN to add the saturating Bubble_cnt_out counter.
module id_ex_pipe_reg #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int CTRL_W      = 16,
    parameter int MEMREAD_BIT = 12
) (
    input  logic              Clk_in,
    input  logic              Rst_in,
    input  logic [CTRL_W-1:0] Ctrl_in,
    input  logic [DATA_W-1:0] PCAddResult_in,
    input  logic [DATA_W-1:0] ReadData1_in,
    input  logic [DATA_W-1:0] ReadData2_in,
    input  logic [DATA_W-1:0] SignExt_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              Flush_in,
    output logic [CTRL_W-1:0] Ctrl_out,
    output logic [DATA_W-1:0] PCAddResult_out,
    output logic [DATA_W-1:0] ReadData1_out,
    output logic [DATA_W-1:0] ReadData2_out,
    output logic [DATA_W-1:0] SignExt_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              Valid_out,
    output logic              Stall_out
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [15:0]       Bubble_cnt_out
`endif
);
    logic load_use;
    logic bubble;

    // $zero as a load target is never a hazard; only rt of the load is its destination
    assign load_use = Valid_out & Ctrl_out[MEMREAD_BIT] & (rt_out != '0) &
                      ((rt_out == rs_in) | (rt_out == rt_in));
    assign Stall_out = load_use & ~Flush_in;
    assign bubble    = Flush_in | load_use;

    always_ff @(posedge Clk_in) begin
        if (Rst_in) begin
            Ctrl_out        <= '0;
            PCAddResult_out <= '0;
            ReadData1_out   <= '0;
            ReadData2_out   <= '0;
            SignExt_out     <= '0;
            rs_out          <= '0;
            rt_out          <= '0;
            rd_out          <= '0;
            Valid_out       <= 1'b0;
        end else if (bubble) begin
            Ctrl_out  <= '0;
            Valid_out <= 1'b0;
        end else begin
            Ctrl_out        <= Ctrl_in;
            PCAddResult_out <= PCAddResult_in;
            ReadData1_out   <= ReadData1_in;
            ReadData2_out   <= ReadData2_in;
            SignExt_out     <= SignExt_in;
            rs_out          <= rs_in;
            rt_out          <= rt_in;
            rd_out          <= rd_in;
            Valid_out       <= 1'b1;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge Clk_in) begin
        if (Rst_in)
            Bubble_cnt_out <= '0;
        else if (bubble && Bubble_cnt_out != 16'hFFFF)
            Bubble_cnt_out <= Bubble_cnt_out + 16'd1;
    end
`endif
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed vectors with a queue scoreboard checked by a separate monitor.
module tb_id_ex_pipe_reg;
    localparam logic [15:0] ADD = 16'h8420;
    localparam logic [15:0] LW  = 16'hD00B;

    typedef struct {
        logic        stall;
        logic [15:0] ctrl;
        logic [31:0] pc, r1, r2, se;
        logic [4:0]  rs, rt, rd;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] ctrl_in;
    logic [31:0] pc_in, r1_in, r2_in, se_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic [15:0] ctrl_out;
    logic [31:0] pc_out, r1_out, r2_out, se_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic        valid_out, stall_out;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] cnt_out;
`endif

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .Clk_in(clk), .Rst_in(rst), .Ctrl_in(ctrl_in), .PCAddResult_in(pc_in),
        .ReadData1_in(r1_in), .ReadData2_in(r2_in), .SignExt_in(se_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .Flush_in(flush),
        .Ctrl_out(ctrl_out), .PCAddResult_out(pc_out), .ReadData1_out(r1_out),
        .ReadData2_out(r2_out), .SignExt_out(se_out), .rs_out(rs_out),
        .rt_out(rt_out), .rd_out(rd_out), .Valid_out(valid_out), .Stall_out(stall_out)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .Bubble_cnt_out(cnt_out)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs applied after one edge; stall is judged mid-cycle, registered outputs after the next edge.
    task automatic row(input logic r, f, input logic [15:0] c, input logic [31:0] pc, a, b, s,
                       input logic [4:0] xs, xt, xd, input exp_t e);
        @(posedge clk);
        #2;
        rst = r; flush = f; ctrl_in = c; pc_in = pc; r1_in = a; r2_in = b; se_in = s;
        rs_in = xs; rt_in = xt; rd_in = xd;
        q.push_back(e);
    endtask

    function automatic exp_t mk(input logic st, input logic [15:0] c, input logic [31:0] pc, a, b, s,
                                input logic [4:0] xs, xt, xd, input logic v, input logic [15:0] n);
        exp_t e;
        e.stall = st; e.ctrl = c; e.pc = pc; e.r1 = a; e.r2 = b; e.se = s;
        e.rs = xs; e.rt = xt; e.rd = xd; e.valid = v; e.cnt = n;
        return e;
    endfunction

    initial begin : monitor
        logic s;
        exp_t e;
        forever begin
            @(negedge clk);
            s = stall_out;
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stall", {31'd0, s}, {31'd0, e.stall});
                chk("ctrl", {16'd0, ctrl_out}, {16'd0, e.ctrl});
                chk("pc4", pc_out, e.pc);
                chk("rd1", r1_out, e.r1);
                chk("rd2", r2_out, e.r2);
                chk("sext", se_out, e.se);
                chk("rs", {27'd0, rs_out}, {27'd0, e.rs});
                chk("rt", {27'd0, rt_out}, {27'd0, e.rt});
                chk("rd", {27'd0, rd_out}, {27'd0, e.rd});
                chk("valid", {31'd0, valid_out}, {31'd0, e.valid});
`ifdef ID_EX_BUBBLE_CNT_EN
                chk("bubble_cnt", {16'd0, cnt_out}, {16'd0, e.cnt});
`endif
            end
        end
    end

    initial begin : driver
        rst = 1'b1; flush = 1'b0; ctrl_in = LW; pc_in = 32'hDEAD; r1_in = 32'h1;
        r2_in = 32'h2; se_in = 32'h3; rs_in = 5'd8; rt_in = 5'd8; rd_in = 5'd9;
        // second reset cycle with nonzero inputs
        row(1, 0, LW, 32'hDEAD, 32'h1, 32'h2, 32'h3, 8, 8, 9,
            mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        row(0, 0, ADD, 32'h104, 32'h11, 32'h22, 32'h7, 3, 4, 5,
            mk(0, ADD, 32'h104, 32'h11, 32'h22, 32'h7, 3, 4, 5, 1, 0));
        row(0, 0, LW, 32'h108, 32'h200, 32'h0, 32'h10, 2, 8, 0,
            mk(0, LW, 32'h108, 32'h200, 32'h0, 32'h10, 2, 8, 0, 1, 0));
        // load-use on rs: stall, bubble with held data
        row(0, 0, ADD, 32'h10C, 32'h33, 32'h44, 32'h0, 8, 9, 10,
            mk(1, 0, 32'h108, 32'h200, 32'h0, 32'h10, 2, 8, 0, 0, 1));
        row(0, 0, ADD, 32'h10C, 32'h33, 32'h44, 32'h0, 8, 9, 10,
            mk(0, ADD, 32'h10C, 32'h33, 32'h44, 32'h0, 8, 9, 10, 1, 1));
        row(0, 0, LW, 32'h110, 32'h300, 32'h0, 32'h20, 1, 0, 0,
            mk(0, LW, 32'h110, 32'h300, 32'h0, 32'h20, 1, 0, 0, 1, 1));
        // load into $zero never stalls
        row(0, 0, ADD, 32'h114, 32'h0, 32'h0, 32'h0, 0, 0, 6,
            mk(0, ADD, 32'h114, 32'h0, 32'h0, 32'h0, 0, 0, 6, 1, 1));
        row(0, 0, LW, 32'h118, 32'h400, 32'h0, 32'h4, 1, 7, 9,
            mk(0, LW, 32'h118, 32'h400, 32'h0, 32'h4, 1, 7, 9, 1, 1));
        // consumer reads the load's rd field and $ra: no hazard
        row(0, 0, ADD, 32'h11C, 32'h55, 32'h66, 32'h0, 9, 31, 9,
            mk(0, ADD, 32'h11C, 32'h55, 32'h66, 32'h0, 9, 31, 9, 1, 1));
        row(0, 0, LW, 32'h120, 32'h500, 32'h0, 32'h8, 1, 12, 0,
            mk(0, LW, 32'h120, 32'h500, 32'h0, 32'h8, 1, 12, 0, 1, 1));
        // load-use on rt with flush: flush wins, no stall, one bubble
        row(0, 1, ADD, 32'h124, 32'h77, 32'h88, 32'h0, 3, 12, 13,
            mk(0, 0, 32'h120, 32'h500, 32'h0, 32'h8, 1, 12, 0, 0, 2));
        row(0, 0, LW, 32'h128, 32'h600, 32'h0, 32'hC, 1, 14, 0,
            mk(0, LW, 32'h128, 32'h600, 32'h0, 32'hC, 1, 14, 0, 1, 2));
        // reset during a stall cycle clears everything
        row(1, 0, ADD, 32'h12C, 32'h99, 32'hAA, 32'h0, 14, 2, 3,
            mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        row(0, 0, ADD, 32'h12C, 32'h99, 32'hAA, 32'h0, 14, 2, 3,
            mk(0, ADD, 32'h12C, 32'h99, 32'hAA, 32'h0, 14, 2, 3, 1, 0));
`ifdef ID_EX_BUBBLE_CNT_EN
        for (int i = 1; i <= 65537; i++)
            row(0, 1, LW, 32'h130, 32'h1, 32'h2, 32'h3, 4, 5, 6,
                mk(0, 0, 32'h12C, 32'h99, 32'hAA, 32'h0, 14, 2, 3, 0,
                   (i >= 65535) ? 16'hFFFF : i[15:0]));
        row(1, 0, LW, 32'h130, 32'h1, 32'h2, 32'h3, 4, 5, 6,
            mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
